// File: rtl/prog_ctr_fsm_if.sv
// Fetch-side bus between the program counter sequencer and its environment.
// Carries br_taken_cnt only when BR_TAKEN_CNT_EN is defined.
interface prog_ctr_fsm_if #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 2
);
  logic              start;
  logic              stall;
  logic              halt;
  logic              branch_abs;
  logic              branch_rel_en;
  logic              zero;
  logic [LUT_AW-1:0] branch_idx;
  logic [LUT_AW-1:0] lut_addr;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   prog_ctr;
  logic              done;
`ifdef BR_TAKEN_CNT_EN
  logic [15:0]       br_taken_cnt;

  modport master (
    output start, stall, halt, branch_abs, branch_rel_en, zero, branch_idx, target,
    input  lut_addr, prog_ctr, done, br_taken_cnt
  );
  modport slave (
    input  start, stall, halt, branch_abs, branch_rel_en, zero, branch_idx, target,
    output lut_addr, prog_ctr, done, br_taken_cnt
  );
`else
  modport master (
    output start, stall, halt, branch_abs, branch_rel_en, zero, branch_idx, target,
    input  lut_addr, prog_ctr, done
  );
  modport slave (
    input  start, stall, halt, branch_abs, branch_rel_en, zero, branch_idx, target,
    output lut_addr, prog_ctr, done
  );
`endif
endinterface

// File: rtl/prog_ctr_fsm.sv
// Program counter / fetch sequencer driving the branch-target LUT.
// Optional taken-branch counter enabled by defining BR_TAKEN_CNT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | after reset, PC held at 0, waiting for start
// ST_ARMED | start seen, PC forced to 0, waiting for start to drop
// ST_RUN   | fetching: stall / halt / abs / rel / increment
// ST_DONE  | halted, PC frozen, done high until the next start
module prog_ctr_fsm #(
  parameter int PC_W = 10
) (
  input logic         clk,
  input logic         reset,
  prog_ctr_fsm_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]      state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic            done_q;
  logic            taken;

  // Index goes straight through so target feeds the next-PC mux in the same cycle.
  assign bus.lut_addr = bus.branch_idx;
  assign bus.prog_ctr = pc;
  assign bus.done     = done_q;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    taken     = 1'b0;
    case (state)
      ST_IDLE: begin
        pc_nxt = '0;
        if (bus.start) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        pc_nxt = '0;
        if (!bus.start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stall) begin
          pc_nxt = pc;
        end else if (bus.halt) begin
          state_nxt = ST_DONE;
        end else if (bus.branch_abs) begin
          pc_nxt = bus.target;
          taken  = 1'b1;
        end else if (bus.branch_rel_en && bus.zero) begin
          pc_nxt = pc + bus.target;
          taken  = 1'b1;
        end else begin
          pc_nxt = pc + PC_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_nxt = ST_ARMED;
          pc_nxt    = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        pc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      pc     <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      done_q <= (state_nxt == ST_DONE);
    end
  end

`ifdef BR_TAKEN_CNT_EN
  logic [15:0] cnt;

  assign bus.br_taken_cnt = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == ST_ARMED && state_nxt == ST_RUN) begin
      cnt <= '0;
    end else if (taken && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end
`else
  logic unused_taken;
  assign unused_taken = taken;
`endif
endmodule

// File: tb/tb_prog_ctr_fsm.sv
// Self-checking bench for prog_ctr_fsm: directed test-plan cases followed by
// randomized traffic, both checked against a behavioural reference model.
module tb_prog_ctr_fsm;
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  prog_ctr_fsm_if #(.PC_W(10), .LUT_AW(2)) bus ();

  prog_ctr_fsm #(.PC_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          m_mode;
  logic [9:0]  m_pc;
  logic        m_done;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic sl, input logic hl, input logic ba,
                       input logic br, input logic z, input logic [9:0] tg);
    logic [1:0] idx;
    idx = 2'($urandom_range(0, 3));
    bus.start         = st;
    bus.stall         = sl;
    bus.halt          = hl;
    bus.branch_abs    = ba;
    bus.branch_rel_en = br;
    bus.zero          = z;
    bus.target        = tg;
    bus.branch_idx    = idx;
  endtask

  // Advance one clock: predict from the spec rules, then compare after the edge.
  task automatic step();
    int   nmode;
    int   npc;
    int   ncnt;
    bit   tk;
    logic [1:0] idx;
    nmode = m_mode;
    npc   = int'(m_pc);
    ncnt  = m_cnt;
    tk    = 0;
    idx   = bus.branch_idx;
    #1;
    check("lut_addr", 32'(bus.lut_addr), 32'(idx));
    if (reset) begin
      nmode = M_IDLE; npc = 0; ncnt = 0;
    end else if (m_mode == M_IDLE) begin
      npc = 0;
      if (bus.start) nmode = M_ARMED;
    end else if (m_mode == M_ARMED) begin
      npc = 0;
      if (!bus.start) begin nmode = M_RUN; ncnt = 0; end
    end else if (m_mode == M_RUN) begin
      if (bus.stall) begin
        npc = int'(m_pc);
      end else if (bus.halt) begin
        nmode = M_DONE;
      end else if (bus.branch_abs) begin
        npc = int'(bus.target); tk = 1;
      end else if (bus.branch_rel_en && bus.zero) begin
        npc = (int'(m_pc) + int'(bus.target)) % 1024; tk = 1;
      end else begin
        npc = (int'(m_pc) + 1) % 1024;
      end
    end else begin
      if (bus.start) begin nmode = M_ARMED; npc = 0; end
    end
    if (tk && ncnt < 65535) ncnt++;
    @(posedge clk);
    #1;
    m_mode = nmode;
    m_pc   = npc[9:0];
    m_done = (nmode == M_DONE);
    m_cnt  = ncnt;
    check("prog_ctr", 32'(bus.prog_ctr), 32'(m_pc));
    check("done", 32'(bus.done), 32'(m_done));
`ifdef BR_TAKEN_CNT_EN
    check("br_taken_cnt", 32'(bus.br_taken_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic jump(input logic [9:0] tg);
    drive(0, 0, 0, 1, 0, 0, tg);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_mode   = M_IDLE;
    m_pc     = '0;
    m_done   = 1'b0;
    m_cnt    = 0;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 10'h000);
    @(posedge clk);
    step();
    check("reset_pc", 32'(bus.prog_ctr), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    reset = 1'b0;

    // start held three cycles, then released: counting starts from 0
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 0, 0, 0, 10'h000); step(); end
    drive(0, 0, 0, 0, 0, 0, 10'h000); step();
    check("first_fetch", 32'(bus.prog_ctr), 32'h0);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 10'h000); step(); end
    check("seq_3", 32'(bus.prog_ctr), 32'h3);

    jump(10'h014);
    drive(0, 0, 0, 0, 1, 1, 10'h3F0); step();
    check("rel_taken", 32'(bus.prog_ctr), 32'h004);
    jump(10'h014);
    drive(0, 0, 0, 0, 1, 0, 10'h3F0); step();
    check("rel_fallthru", 32'(bus.prog_ctr), 32'h015);
    jump(10'h100);
    drive(0, 0, 0, 1, 1, 1, 10'h007); step();
    check("abs_wins", 32'(bus.prog_ctr), 32'h007);
    drive(0, 1, 1, 1, 0, 0, 10'h222); step(); step();
    check("stall_pc", 32'(bus.prog_ctr), 32'h007);
    check("stall_done", 32'(bus.done), 32'h0);
    jump(10'h3FF);
    drive(0, 0, 0, 0, 0, 0, 10'h000); step();
    check("wrap", 32'(bus.prog_ctr), 32'h000);

    jump(10'h025);
    check("pre_reset_pc", 32'(bus.prog_ctr), 32'h025);
    reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 10'h000); step();
    reset = 1'b0;
    check("mid_run_reset", 32'(bus.prog_ctr), 32'h0);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 10'h000); step(); end
    check("idle_hold", 32'(bus.prog_ctr), 32'h0);

    drive(1, 0, 0, 0, 0, 0, 10'h000); step();
    drive(0, 0, 0, 0, 0, 0, 10'h000); step();
    jump(10'h010);
    drive(0, 0, 0, 0, 1, 1, 10'h010); step();
    jump(10'h030);
    drive(0, 0, 1, 0, 0, 0, 10'h000); step();
    check("halt_done", 32'(bus.done), 32'h1);
    check("halt_pc", 32'(bus.prog_ctr), 32'h030);
`ifdef BR_TAKEN_CNT_EN
    check("cnt_three", 32'(bus.br_taken_cnt), 32'h3);
`endif
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            10'($urandom));
      step();
    end
    check("done_hold_pc", 32'(bus.prog_ctr), 32'h030);
    drive(1, 0, 0, 0, 0, 0, 10'h000); step();
    check("restart_done", 32'(bus.done), 32'h0);
    check("restart_pc", 32'(bus.prog_ctr), 32'h0);

    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
            10'($urandom));
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
